// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM states,
// segment codes (active-low, {a,b,c,d,e,f,g} in [6:0]) and the BCD decode.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Index 9 is the leftmost element of the concatenation.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        seg = SEG_DASH;
        for (int i = 0; i < 10; i++) begin
            if (bcd == 4'(i)) begin
                seg = SEG_DIGITS[i];
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/ssd_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15
// show a dash.
module ssd_decode
    import ssd_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg_decode(bcd);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver: shadow register, guard/drive
// slot FSM, leading-zero blanking and registered active-low outputs.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int N_DIGITS     = 6,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        load,
    input  logic [4*N_DIGITS-1:0]       bcd_bus,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic [N_DIGITS-1:0]         blank_mask,
    output logic [6:0]                  ssd,
    output logic                        dp_n,
    output logic [N_DIGITS-1:0]         an_n,
    output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] scan_idx
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   bcd_sh_q, bcd_sh_d;
    logic [N_DIGITS-1:0]     dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]     blank_sh_q, blank_sh_d;
    logic [6:0]              ssd_q, ssd_d;
    logic                    dp_n_q, dp_n_d;
    logic [N_DIGITS-1:0]     an_n_q, an_n_d;

    logic                    start_slot;
    logic [N_DIGITS-1:0]     lz_mask;
    logic                    seen_nz;
    logic [3:0]              sel_digit;
    logic                    sel_dp;
    logic                    sel_blank;
    logic [6:0]              sel_seg;

    always_comb begin
        bcd_sh_d   = load ? bcd_bus    : bcd_sh_q;
        dp_sh_d    = load ? dp_in      : dp_sh_q;
        blank_sh_d = load ? blank_mask : blank_sh_q;
    end

    // Blank leading zeros from the top digit down; a lit decimal point or any
    // nonzero code ends the run, and digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (!seen_nz && (bcd_sh_q[i*4 +: 4] == 4'd0) && !dp_sh_q[i]) begin
                lz_mask[i] = (LZ_BLANK != 0);
            end else begin
                seen_nz = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        start_slot = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (GUARD_CYCLES == 0) begin
                        state_d    = ST_DRIVE;
                        start_slot = 1'b1;
                    end else begin
                        state_d = ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d      = '0;
                        state_d    = ST_DRIVE;
                        start_slot = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        cnt_d = '0;
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        if (GUARD_CYCLES == 0) begin
                            start_slot = 1'b1;
                        end else begin
                            state_d = ST_GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Select the digit of the slot about to start; the shadow is read before
    // a coincident load lands, so that slot still shows the old contents.
    always_comb begin
        sel_digit = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_digit = bcd_sh_q[i*4 +: 4];
                sel_dp    = dp_sh_q[i];
                sel_blank = blank_sh_q[i] | lz_mask[i];
            end
        end
    end

    ssd_decode u_decode (
        .bcd (sel_digit),
        .seg (sel_seg)
    );

    always_comb begin
        ssd_d  = ssd_q;
        dp_n_d = dp_n_q;
        an_n_d = an_n_q;
        if (start_slot) begin
            if (sel_blank) begin
                ssd_d  = SEG_BLANK;
                dp_n_d = 1'b1;
                an_n_d = '1;
            end else begin
                ssd_d  = sel_seg;
                dp_n_d = ~sel_dp;
                for (int i = 0; i < N_DIGITS; i++) begin
                    an_n_d[i] = (idx_d != IDX_W'(i));
                end
            end
        end else if (state_d != ST_DRIVE) begin
            ssd_d  = SEG_BLANK;
            dp_n_d = 1'b1;
            an_n_d = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            bcd_sh_q   <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
            ssd_q      <= SEG_BLANK;
            dp_n_q     <= 1'b1;
            an_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            bcd_sh_q   <= bcd_sh_d;
            dp_sh_q    <= dp_sh_d;
            blank_sh_q <= blank_sh_d;
            ssd_q      <= ssd_d;
            dp_n_q     <= dp_n_d;
            an_n_q     <= an_n_d;
        end
    end

    assign ssd      = ssd_q;
    assign dp_n     = dp_n_q;
    assign an_n     = an_n_q;
    assign scan_idx = idx_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits, 4-cycle drive slots and
// one guard cycle; expected segment codes are written out by hand.
module tb_ssd_scan_driver;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_D = 7'b1111110;
    localparam logic [6:0] SEG_B = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] bcd_bus;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [6:0]  ssd;
    logic        dp_n;
    logic [3:0]  an_n;
    logic [1:0]  scan_idx;

    int n_vectors     = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .N_DIGITS     (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .bcd_bus    (bcd_bus),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .ssd        (ssd),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .scan_idx   (scan_idx)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Park in IDLE, load the shadow, re-enable and step to the first drive
    // cycle of slot 0, checking the single guard cycle on the way.
    task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] blank);
        enable     = 1'b0;
        load       = 1'b1;
        bcd_bus    = bcd;
        dp_in      = dp;
        blank_mask = blank;
        stepClock();
        load   = 1'b0;
        enable = 1'b1;
        stepClock();
        checkOutput("start_guard_an", 32'(an_n), 32'hF);
        checkOutput("start_guard_idx", 32'(scan_idx), 32'd0);
        stepClock();
    endtask

    task automatic checkSlot(input string tag, input int idx, input logic [6:0] e_ssd,
                             input logic e_dp, input logic [3:0] e_an);
        for (int c = 0; c < 4; c++) begin
            checkOutput({tag, "/ssd"}, 32'(ssd), 32'(e_ssd));
            checkOutput({tag, "/dp_n"}, 32'(dp_n), 32'(e_dp));
            checkOutput({tag, "/an_n"}, 32'(an_n), 32'(e_an));
            checkOutput({tag, "/idx"}, 32'(scan_idx), 32'(idx));
            stepClock();
        end
        checkOutput({tag, "/guard_an"}, 32'(an_n), 32'hF);
        stepClock();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b1;
        enable     = 1'b0;
        load       = 1'b0;
        bcd_bus    = '0;
        dp_in      = '0;
        blank_mask = '0;
        #2 rst_n = 1'b0;
        stepClock();
        stepClock();
        checkOutput("reset_ssd", 32'(ssd), 32'(SEG_B));
        checkOutput("reset_dp", 32'(dp_n), 32'd1);
        checkOutput("reset_an", 32'(an_n), 32'hF);
        checkOutput("reset_idx", 32'(scan_idx), 32'd0);
        rst_n = 1'b1;

        applyStimulus(16'h1234, 4'b0000, 4'b0000);
        checkSlot("p1234_s0", 0, SEG_4, 1'b1, 4'b1110);
        checkSlot("p1234_s1", 1, SEG_3, 1'b1, 4'b1101);
        checkSlot("p1234_s2", 2, SEG_2, 1'b1, 4'b1011);
        checkSlot("p1234_s3", 3, SEG_1, 1'b1, 4'b0111);
        checkOutput("period_ssd", 32'(ssd), 32'(SEG_4));
        checkOutput("period_an", 32'(an_n), 32'hE);
        checkOutput("period_idx", 32'(scan_idx), 32'd0);

        stepClock();
        load    = 1'b1;
        bcd_bus = 16'h5555;
        checkOutput("middrive_c2", 32'(ssd), 32'(SEG_4));
        stepClock();
        load = 1'b0;
        checkOutput("middrive_c3", 32'(ssd), 32'(SEG_4));
        stepClock();
        checkOutput("middrive_c4", 32'(ssd), 32'(SEG_4));
        stepClock();
        checkOutput("middrive_guard", 32'(an_n), 32'hF);
        stepClock();
        checkOutput("newload_s1_ssd", 32'(ssd), 32'(SEG_5));
        checkOutput("newload_s1_an", 32'(an_n), 32'hD);

        stepClock();
        enable = 1'b0;
        stepClock();
        checkOutput("disable_an", 32'(an_n), 32'hF);
        checkOutput("disable_ssd", 32'(ssd), 32'(SEG_B));
        checkOutput("disable_dp", 32'(dp_n), 32'd1);
        checkOutput("disable_idx", 32'(scan_idx), 32'd0);
        stepClock();
        checkOutput("idle_an", 32'(an_n), 32'hF);
        enable = 1'b1;
        stepClock();
        checkOutput("reen_guard_an", 32'(an_n), 32'hF);
        checkOutput("reen_guard_idx", 32'(scan_idx), 32'd0);
        stepClock();
        checkOutput("reen_s0_ssd", 32'(ssd), 32'(SEG_5));
        checkOutput("reen_s0_an", 32'(an_n), 32'hE);

        applyStimulus(16'h00A7, 4'b0000, 4'b0000);
        checkSlot("p00A7_s0", 0, SEG_7, 1'b1, 4'b1110);
        checkSlot("p00A7_s1", 1, SEG_D, 1'b1, 4'b1101);
        checkSlot("p00A7_s2", 2, SEG_B, 1'b1, 4'b1111);
        checkSlot("p00A7_s3", 3, SEG_B, 1'b1, 4'b1111);

        applyStimulus(16'h0000, 4'b0000, 4'b0000);
        checkSlot("p0000_s0", 0, SEG_0, 1'b1, 4'b1110);
        checkSlot("p0000_s1", 1, SEG_B, 1'b1, 4'b1111);
        checkSlot("p0000_s2", 2, SEG_B, 1'b1, 4'b1111);
        checkSlot("p0000_s3", 3, SEG_B, 1'b1, 4'b1111);

        applyStimulus(16'h1234, 4'b0100, 4'b0010);
        checkSlot("mask_s0", 0, SEG_4, 1'b1, 4'b1110);
        checkSlot("mask_s1", 1, SEG_B, 1'b1, 4'b1111);
        checkSlot("mask_s2", 2, SEG_2, 1'b0, 4'b1011);
        checkSlot("mask_s3", 3, SEG_1, 1'b1, 4'b0111);

        applyStimulus(16'h1234, 4'b0000, 4'b0000);
        repeat (4) stepClock();
        checkOutput("boundary_guard", 32'(an_n), 32'hF);
        load    = 1'b1;
        bcd_bus = 16'h8888;
        stepClock();
        load = 1'b0;
        checkOutput("boundary_old_ssd", 32'(ssd), 32'(SEG_3));
        checkOutput("boundary_old_an", 32'(an_n), 32'hD);
        repeat (5) stepClock();
        checkOutput("boundary_new_ssd", 32'(ssd), 32'(SEG_8));
        checkOutput("boundary_new_an", 32'(an_n), 32'hB);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ssd", 32'(ssd), 32'(SEG_B));
        checkOutput("async_rst_dp", 32'(dp_n), 32'd1);
        checkOutput("async_rst_an", 32'(an_n), 32'hF);
        checkOutput("async_rst_idx", 32'(scan_idx), 32'd0);
        #1 rst_n = 1'b1;
        stepClock();
        checkOutput("post_rst_guard", 32'(an_n), 32'hF);
        stepClock();
        checkOutput("post_rst_shadow0", 32'(ssd), 32'(SEG_0));
        checkOutput("post_rst_an", 32'(an_n), 32'hE);

        applyStimulus(16'h0042, 4'b0000, 4'b0000);
        checkSlot("p0042_s0", 0, SEG_2, 1'b1, 4'b1110);
        checkSlot("p0042_s1", 1, SEG_4, 1'b1, 4'b1101);
        checkSlot("p0042_s2", 2, SEG_B, 1'b1, 4'b1111);
        checkSlot("p0042_s3", 3, SEG_B, 1'b1, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
